// File: rtl/dmem_responder.sv
// Word-addressed 64-bit data memory with a fixed wait-state count and a one-cycle ready strobe.
// Define DMEM_RANGE_CHECK_EN to flag out-of-range accesses with err; otherwise the address wraps modulo DEPTH.
module dmem_responder #(
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        mem_rw,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rw_q, rw_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;

  logic [63:0] DM [DEPTH];

  logic          cur_rw;
  logic [63:0]   cur_addr;
  logic [63:0]   cur_wdata;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          fire;
  logic          we;

  // With zero wait states the response edge is the sampling edge, so the
  // transaction is taken straight from the ports instead of the latches.
  always_comb begin
    cur_rw    = (state_q == IDLE) ? mem_rw : rw_q;
    cur_addr  = (state_q == IDLE) ? addr   : addr_q;
    cur_wdata = (state_q == IDLE) ? wdata  : wdata_q;
    idx       = cur_addr[AW-1:0];
`ifdef DMEM_RANGE_CHECK_EN
    in_range  = (cur_addr < 64'(DEPTH));
`else
    in_range  = 1'b1;
`endif
  end

`ifndef DMEM_RANGE_CHECK_EN
  logic unused_addr_hi;
  assign unused_addr_hi = ^cur_addr[63:AW];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    fire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          rw_d    = mem_rw;
          addr_d  = addr;
          wdata_d = wdata;
          if (WAIT_CYCLES == 0) begin
            fire = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) fire = 1'b1;
        else               cnt_d = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (fire) begin
      state_d = RESP;
      ready_d = 1'b1;
      err_d   = !in_range;
      if (!cur_rw) rdata_d = in_range ? DM[idx] : '0;
    end
  end

  // Gated by rst so a request held during reset can never commit.
  assign we = fire && cur_rw && in_range && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) DM[idx] <= cur_wdata;
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;

endmodule
